// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU: op encodings, FSM states, nibble width.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/add4.sv
// 4-bit ripple-carry adder used as the single datapath adder of the nibble-serial ALU.
module add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[4];

endmodule

// File: rtl/add8_nibble_seq.sv
// Nibble-serial add/subtract: one 4-bit adder is reused WIDTH/4 times, carry held in a register.
// done and the flags are registered together on the edge that leaves DONE.
module add8_nibble_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy,
  output logic             done
);
  import alu_pkg::*;

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e state_q, state_d;

  logic [CntW-1:0]     cnt_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q, b_q;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                cout_q, ovf_q, zero_q, done_q;

  logic                load_en, calc_en, fin_en;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StCalc;
      StCalc:  if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs and datapath enables
  always_comb begin
    busy    = (state_q != StIdle);
    load_en = 1'b0;
    calc_en = 1'b0;
    fin_en  = 1'b0;
    unique case (state_q)
      StIdle:  load_en = start;
      StCalc:  calc_en = 1'b1;
      StDone:  fin_en  = 1'b1;
      default: ;
    endcase
  end

  // Operand nibble select
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CntW'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  add4 u_add4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Result nibble write-back
  always_comb begin
    result_d = result_q;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (cnt_q == CntW'(i)) begin
        result_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_en) begin
        a_q     <= a;
        b_q     <= (op == OP_SUB) ? ~b : b;
        cnt_q   <= '0;
        carry_q <= op;  // +1 completes the two's complement of b for subtract
      end
      if (calc_en) begin
        result_q <= result_d;
        carry_q  <= nib_cout;
        cnt_q    <= cnt_q + 1'b1;
      end
      if (fin_en) begin
        done_q <= 1'b1;
        cout_q <= carry_q;
        zero_q <= (result_q == '0);
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result_q[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
  assign done   = done_q;

endmodule

// File: tb/tb_add8_nibble_seq.sv
// Self-checking bench for add8_nibble_seq: directed cases plus random ops vs an arithmetic model.
module tb_add8_nibble_seq;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned LAT     = NIBBLES + 2;

  logic             clk, rst, start, op;
  logic [WIDTH-1:0] a, b, result;
  logic             cout, ovf, zero, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  add8_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operand values.
  function automatic void model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                input logic mop, output logic [WIDTH-1:0] r,
                                output logic c, output logic v, output logic z);
    longint ua, ub, sa, sb, full, sres;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = ma[WIDTH-1] ? ua - (longint'(1) << WIDTH) : ua;
    sb = mb[WIDTH-1] ? ub - (longint'(1) << WIDTH) : ub;
    if (mop) begin
      full = ua - ub;
      c    = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub;
      c    = (full >= (longint'(1) << WIDTH));
      sres = sa + sb;
    end
    r = full[WIDTH-1:0];
    v = (sres > (longint'(1) << (WIDTH - 1)) - 1) || (sres < -(longint'(1) << (WIDTH - 1)));
    z = (r == '0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic [WIDTH-1:0] ta,
                               input logic [WIDTH-1:0] tb, input logic top);
    logic [WIDTH-1:0] er;
    logic ec, ev, ez;
    model(ta, tb, top, er, ec, ev, ez);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(ev));
    check({tag, "_zero"}, 32'(zero), 32'(ez));
  endtask

  // One operation from IDLE; operands are scrambled after acceptance.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta,
                       input logic [WIDTH-1:0] tb, input logic top);
    int n;
    a = ta; b = tb; op = top; start = 1'b1;
    tick();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); op = 1'($urandom);
    n = 1;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    check_outputs(tag, ta, tb, top);
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check_outputs({tag, "_hold"}, ta, tb, top);
  endtask

  logic [WIDTH-1:0] qa [3];
  logic [WIDTH-1:0] qb [3];
  logic             qop[3];

  initial begin
    int n, ndone;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    tick();
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    do_op("add", 8'h3C, 8'h28, 1'b0);
    do_op("carry", 8'hFF, 8'h01, 1'b0);
    do_op("sub_ovf", 8'h80, 8'h01, 1'b1);
    do_op("sub_borrow", 8'h05, 8'h07, 1'b1);
    do_op("sub_zero", 8'h5A, 8'h5A, 1'b1);
    do_op("add_ovf", 8'h7F, 8'h01, 1'b0);

    // Second start while busy must be ignored.
    a = 8'h11; b = 8'h22; op = 1'b0; start = 1'b1;
    tick();
    a = 8'h55;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) ndone++;
      tick();
    end
    check("busy_rej_dones", 32'(ndone), 32'd1);
    check("busy_rej_result", 32'(result), 32'h33);

    // Reset in the second CALC cycle.
    a = 8'h37; b = 8'h15; op = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_zero", 32'(zero), 32'd1);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      tick();
    end
    check("mid_rst_nodone", 32'(ndone), 32'd0);
    do_op("post_rst", 8'h01, 8'h01, 1'b0);
    check("post_rst_val", 32'(result), 32'h02);

    // Back-to-back with start held high.
    for (int i = 0; i < 3; i++) begin
      qa[i] = WIDTH'($urandom); qb[i] = WIDTH'($urandom); qop[i] = 1'($urandom);
    end
    a = qa[0]; b = qb[0]; op = qop[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!done && n < 20);
      check("b2b_gap", 32'(n), 32'(LAT));
      check_outputs("b2b", qa[i], qb[i], qop[i]);
      if (i < 2) begin
        a = qa[i + 1]; b = qb[i + 1]; op = qop[i + 1];
      end
    end
    start = 1'b0;
    tick();
    check("b2b_idle", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      do_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
